// File: rtl/eth_dist_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_dist_ram_fifo_pkg
//  Description : Shared defaults and types for the Ethernet distributed-RAM
//                data FIFO. Defining the ETH_FIFO_XILINX macro at compile
//                time selects LUT-RAM primitives for the storage array.
//                Without it, the storage is an inferred register array.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_dist_ram_fifo_pkg;

  // Default geometry of the MAC TX/RX data FIFOs.
  localparam int ETH_FIFO_DATA_WIDTH = 32;
  localparam int ETH_FIFO_DEPTH      = 16;

  // Registered occupancy flags, all derived from the same next-state count.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

endpackage : eth_dist_ram_fifo_pkg
`default_nettype wire

// File: rtl/eth_dist_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : eth_dist_ram_dp
//  Description : Dual-port distributed RAM with a synchronous write and an
//                asynchronous read. The RAM has no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_dist_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

`ifdef ETH_FIFO_XILINX
  if (ADDR_WIDTH == 4) begin : g_ram16
    // One 16x1 dual-port LUT-RAM per data bit; DPO is the read port.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
      RAM16X1D u_ram (
        .D(wdata[i]), .WE(we), .WCLK(clk),
        .A0(waddr[0]), .A1(waddr[1]), .A2(waddr[2]), .A3(waddr[3]),
        .DPRA0(raddr[0]), .DPRA1(raddr[1]), .DPRA2(raddr[2]), .DPRA3(raddr[3]),
        .SPO(), .DPO(rdata[i])
      );
    end
  end else if (ADDR_WIDTH == 5) begin : g_ram32
    // One 32x1 dual-port LUT-RAM per data bit.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
      RAM32X1D u_ram (
        .D(wdata[i]), .WE(we), .WCLK(clk),
        .A0(waddr[0]), .A1(waddr[1]), .A2(waddr[2]), .A3(waddr[3]), .A4(waddr[4]),
        .DPRA0(raddr[0]), .DPRA1(raddr[1]), .DPRA2(raddr[2]), .DPRA3(raddr[3]),
        .DPRA4(raddr[4]),
        .SPO(), .DPO(rdata[i])
      );
    end
  end else begin : g_infer
    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Synchronous write port; primitives only cover 16 and 32 entries.
    always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
  end
`else
  if (1) begin : g_infer
    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Synchronous write port; the read port is purely combinational.
    always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
  end
`endif

endmodule : eth_dist_ram_dp
`default_nettype wire

// File: rtl/eth_dist_ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : eth_dist_ram_fifo
//  Description : Synchronous first-word-fall-through FIFO on distributed RAM.
//                It has an occupancy count, registered full and empty flags,
//                almost-full and almost-empty flags, and overflow/underflow
//                pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_dist_ram_fifo
  import eth_dist_ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = ETH_FIFO_DATA_WIDTH,
  parameter int DEPTH        = ETH_FIFO_DEPTH,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  if (DEPTH < 2 || (1 << ADDR_WIDTH) != DEPTH) begin : g_bad_params
    $error("eth_dist_ram_fifo: DEPTH must be a power of 2 >= 2 and equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc, ram_we;

  // Acceptance, pointer and count update. Flags come from the next count,
  // so they are exact in the same cycle that the new count is visible.
  always_comb begin
    wr_acc      = write & (~flags_q.full | read);
    rd_acc      = read & ~flags_q.empty;
    ram_we      = wr_acc & ~reset & ~clear;
    wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    overflow_d  = write & flags_q.full & ~read;
    underflow_d = read & flags_q.empty;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    flags_d.full         = (cnt_d == DEPTH_LVL);
    flags_d.almost_full  = (cnt_d >= AFULL_LVL) & ~clear;
    flags_d.empty        = (cnt_d == '0);
    flags_d.almost_empty = (cnt_d <= AEMPTY_LVL);
  end

  // State registers; reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      flags_q     <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  eth_dist_ram_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign full         = flags_q.full;
  assign almost_full  = flags_q.almost_full;
  assign empty        = flags_q.empty;
  assign almost_empty = flags_q.almost_empty;
  assign cnt          = cnt_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : eth_dist_ram_fifo
`default_nettype wire

// File: tb/tb_eth_dist_ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_dist_ram_fifo
//  Description : Self-checking bench for eth_dist_ram_fifo. It compares the
//                design against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_dist_ram_fifo;

  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int AEMPTY = 2;

  logic        clk = 1'b0;
  logic        reset, clear, write, read;
  logic [31:0] data_in, data_out;
  logic        full, almost_full, empty, almost_empty, overflow, underflow;
  logic [4:0]  cnt;

  int n_checks   = 0;
  int n_failures = 0;

  // Reference model state.
  logic [31:0] model_q[$];
  logic        exp_ovf = 1'b0;
  logic        exp_unf = 1'b0;

  always #5 clk = ~clk;

  eth_dist_ram_fifo #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(4),
    .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .write(write), .data_in(data_in),
    .read(read), .data_out(data_out), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .cnt(cnt),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The model's view of one rising edge, computed from the pre-edge inputs.
  task automatic model_step(input logic w, input logic r, input logic [31:0] d,
                            input logic clr, input logic rst);
    int sz;
    sz = model_q.size();
    if (rst || clr) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      exp_ovf = w && (sz == DEPTH) && !r;
      exp_unf = r && (sz == 0);
      if (r && sz > 0) void'(model_q.pop_front());
      if (w && (sz < DEPTH || r)) model_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    chk("cnt",          32'(cnt),          32'(sz));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(sz >= AFULL));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AEMPTY));
    chk("overflow",     32'(overflow),     32'(exp_ovf));
    chk("underflow",    32'(underflow),    32'(exp_unf));
    if (sz > 0) chk("data_out", data_out, model_q[0]);
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d,
                     input logic clr, input logic rst);
    write = w; read = r; data_in = d; clear = clr; reset = rst;
    @(posedge clk);
    model_step(w, r, d, clr, rst);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
    #1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Fill with 1..16, then check overflow and a full pass-through.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("passthru_head", data_out, 32'hA5A5_A5A5);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Read from empty with a simultaneous write: no bypass.
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("underflow_head", data_out, 32'h1234_5678);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Random traffic with repeated pointer wraps.
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);

    // Flush at cnt=9, first with clear and then with reset.
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
      chk("pre_flush_cnt", 32'(cnt), 32'd9);
      cyc(1'b1, 1'b1, 32'hBAD0_0000, pass == 0, pass == 1);
      cyc(1'b1, 1'b0, 32'hC0FF_EE00 + 32'(pass), 1'b0, 1'b0);
      chk("post_flush_head", data_out, 32'hC0FF_EE00 + 32'(pass));
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_eth_dist_ram_fifo
`default_nettype wire
